// File: rtl/patch_pkg.sv
// Shared types and helpers for the patch sample node.
//   state_e  : patch engine FSM states
//   target_e : which output(s) an armed patch overrides
//   sat_inc  : saturating increment for counters up to 32 bits wide
package patch_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    ACTIVE = 2'd2
  } state_e;

  // Bit 0 selects out, bit 1 selects out3.
  typedef enum logic [1:0] {
    T_NONE = 2'd0,
    T_OUT  = 2'd1,
    T_OUT3 = 2'd2,
    T_BOTH = 2'd3
  } target_e;

  // Increment v, holding at the all-ones value of a w-bit counter.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] max_v;
    max_v = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    return (v >= max_v) ? max_v : (v + 32'd1);
  endfunction

endpackage : patch_pkg

// File: rtl/patch_trigger_fsm.sv
// Patch engine control: cfg latch, match/trigger FSM, hold counter, hit counter.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   a                             observed input
//   cfg_valid/cfg_ready           configuration handshake (ready only in IDLE)
//   cfg_mask/match/value/hold/target  configuration fields
//   abort                         cancels an armed or active patch
//   patch_active                  override currently applied
//   tgt_out, tgt_out3, value      override selection and value for the datapath
//   done                          one-cycle pulse after a normally completed override
//   hit_cnt                       saturating trigger count
module patch_trigger_fsm
  import patch_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned HOLD_W = 4,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  a,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [WIDTH-1:0]  cfg_mask,
  input  logic [WIDTH-1:0]  cfg_match,
  input  logic [WIDTH-1:0]  cfg_value,
  input  logic [HOLD_W-1:0] cfg_hold,
  input  logic [1:0]        cfg_target,
  input  logic              abort,
  output logic              patch_active,
  output logic              tgt_out,
  output logic              tgt_out3,
  output logic [WIDTH-1:0]  value,
  output logic              done,
  output logic [CNT_W-1:0]  hit_cnt
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   mask_q, match_q, value_q;
  logic [HOLD_W-1:0]  hold_q;
  target_e            target_q;
  logic [HOLD_W-1:0]  cnt_q;
  logic [CNT_W-1:0]   hit_q;
  logic               done_q, active_q, ready_q;

  logic               accept_c, match_c, trigger_c, finish_c;
  logic               done_d, active_d, ready_d;

  assign accept_c = cfg_valid && ready_q;
  assign match_c  = ((a ^ match_q) & mask_q) == '0;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; abort has priority in every state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (!abort && accept_c && (cfg_target != 2'(T_NONE))) state_d = ARMED;
      end
      ARMED: begin
        if (abort)        state_d = IDLE;
        else if (match_c) state_d = ACTIVE;
      end
      ACTIVE: begin
        if (abort || (cnt_q == '0)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    trigger_c = 1'b0;
    finish_c  = 1'b0;
    done_d    = 1'b0;
    active_d  = (state_d == ACTIVE);
    ready_d   = (state_d == IDLE);
    if (state_q == ARMED && !abort && match_c)        trigger_c = 1'b1;
    if (state_q == ACTIVE && !abort && cnt_q == '0)   finish_c  = 1'b1;
    done_d = finish_c;
  end

  // Configuration, counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      mask_q   <= '0;
      match_q  <= '0;
      value_q  <= '0;
      hold_q   <= '0;
      target_q <= T_NONE;
      cnt_q    <= '0;
      hit_q    <= '0;
      done_q   <= 1'b0;
      active_q <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      if (accept_c) begin
        mask_q   <= cfg_mask;
        match_q  <= cfg_match;
        value_q  <= cfg_value;
        hold_q   <= cfg_hold;
        target_q <= target_e'(cfg_target);
      end
      if (trigger_c) begin
        cnt_q <= hold_q;
        hit_q <= CNT_W'(sat_inc(32'(hit_q), CNT_W));
      end else if (state_q == ACTIVE && cnt_q != '0) begin
        cnt_q <= cnt_q - HOLD_W'(1);
      end
      done_q   <= done_d;
      active_q <= active_d;
      ready_q  <= ready_d;
    end
  end

  assign cfg_ready    = ready_q;
  assign patch_active = active_q;
  assign tgt_out      = target_q[0];
  assign tgt_out3     = target_q[1];
  assign value        = value_q;
  assign done         = done_q;
  assign hit_cnt      = hit_q;

endmodule : patch_trigger_fsm

// File: rtl/patch_sample_node.sv
// WIDTH-bit sample node with an integrated patch engine that can override out/out3.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   a, b                datapath inputs (a is also the match source)
//   out                 a & b, or the override value (combinational)
//   out2                ~out | b (combinational, from the final out)
//   out3                registered a, or the override value
//   cfg_*               patch configuration over valid/ready
//   abort               cancels an armed or active patch
//   patch_active, done, hit_cnt  engine status
module patch_sample_node
  import patch_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned HOLD_W = 4,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  output logic [WIDTH-1:0]  out,
  output logic [WIDTH-1:0]  out2,
  output logic [WIDTH-1:0]  out3,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [WIDTH-1:0]  cfg_mask,
  input  logic [WIDTH-1:0]  cfg_match,
  input  logic [WIDTH-1:0]  cfg_value,
  input  logic [HOLD_W-1:0] cfg_hold,
  input  logic [1:0]        cfg_target,
  input  logic              abort,
  output logic              patch_active,
  output logic              done,
  output logic [CNT_W-1:0]  hit_cnt
);

  logic             tgt_out, tgt_out3;
  logic [WIDTH-1:0] value;
  logic [WIDTH-1:0] out3_q;

  patch_trigger_fsm #(
    .WIDTH (WIDTH),
    .HOLD_W(HOLD_W),
    .CNT_W (CNT_W)
  ) u_fsm (
    .clk         (clk),
    .rst         (rst),
    .a           (a),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_mask    (cfg_mask),
    .cfg_match   (cfg_match),
    .cfg_value   (cfg_value),
    .cfg_hold    (cfg_hold),
    .cfg_target  (cfg_target),
    .abort       (abort),
    .patch_active(patch_active),
    .tgt_out     (tgt_out),
    .tgt_out3    (tgt_out3),
    .value       (value),
    .done        (done),
    .hit_cnt     (hit_cnt)
  );

  // Combinational outputs; out2 is derived from the possibly patched out
  assign out  = (patch_active && tgt_out) ? value : (a & b);
  assign out2 = ~out | b;

  // out3 samples the override value instead of a on each ACTIVE edge
  always_ff @(posedge clk) begin
    if (rst)                       out3_q <= '0;
    else if (patch_active && tgt_out3) out3_q <= value;
    else                           out3_q <= a;
  end

  assign out3 = out3_q;

endmodule : patch_sample_node

// File: tb/tb_patch_sample_node.sv
module tb_patch_sample_node;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned HOLD_W = 4;
  localparam int unsigned CNT_W  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [WIDTH-1:0]  a, b;
  logic [WIDTH-1:0]  out, out2, out3;
  logic              cfg_valid, cfg_ready;
  logic [WIDTH-1:0]  cfg_mask, cfg_match, cfg_value;
  logic [HOLD_W-1:0] cfg_hold;
  logic [1:0]        cfg_target;
  logic              abort, patch_active, done;
  logic [CNT_W-1:0]  hit_cnt;

  int errors = 0;
  int checks = 0;
  logic [1:0] exp_hit [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

  always #5 clk = ~clk;

  patch_sample_node #(
    .WIDTH (WIDTH),
    .HOLD_W(HOLD_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .a           (a),
    .b           (b),
    .out         (out),
    .out2        (out2),
    .out3        (out3),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_mask    (cfg_mask),
    .cfg_match   (cfg_match),
    .cfg_value   (cfg_value),
    .cfg_hold    (cfg_hold),
    .cfg_target  (cfg_target),
    .abort       (abort),
    .patch_active(patch_active),
    .done        (done),
    .hit_cnt     (hit_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_cfg(input logic [7:0] m, input logic [7:0] p, input logic [7:0] v,
                         input logic [3:0] h, input logic [1:0] t);
    cfg_valid  = 1'b1;
    cfg_mask   = m;
    cfg_match  = p;
    cfg_value  = v;
    cfg_hold   = h;
    cfg_target = t;
  endtask

  initial begin
    rst = 1'b1; a = '0; b = '0; abort = 1'b0;
    cfg_valid = 1'b0; cfg_mask = '0; cfg_match = '0; cfg_value = '0;
    cfg_hold = '0; cfg_target = '0;
    tick(); tick();

    // Reset state and plain datapath during reset
    chk("rst_out3", 32'(out3), 32'h00);
    chk("rst_hit", 32'(hit_cnt), 32'h0);
    chk("rst_ready", 32'(cfg_ready), 32'h1);
    chk("rst_active", 32'(patch_active), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    a = 8'hF0; b = 8'h3C; #1;
    chk("rst_out", 32'(out), 32'h30);
    chk("rst_out2", 32'(out2), 32'hFF);
    rst = 1'b0;
    tick();
    chk("out3_latency", 32'(out3), 32'hF0);
    chk("ready_idle", 32'(cfg_ready), 32'h1);

    // Target out, hold 2: three override cycles then done
    a = 8'h00;
    set_cfg(8'h0F, 8'h05, 8'hAA, 4'd2, 2'd1);
    tick();
    cfg_valid = 1'b0;
    chk("armed_ready", 32'(cfg_ready), 32'h0);
    chk("armed_out", 32'(out), 32'h00);
    a = 8'h15;
    tick();
    chk("t1_c1_active", 32'(patch_active), 32'h1);
    chk("t1_c1_out", 32'(out), 32'hAA);
    chk("t1_c1_out2", 32'(out2), 32'h7D);
    chk("t1_hit", 32'(hit_cnt), 32'h1);
    tick();
    chk("t1_c2_out", 32'(out), 32'hAA);
    chk("t1_c2_done", 32'(done), 32'h0);
    tick();
    chk("t1_c3_out", 32'(out), 32'hAA);
    chk("t1_c3_done", 32'(done), 32'h0);
    tick();
    chk("t1_end_active", 32'(patch_active), 32'h0);
    chk("t1_end_out", 32'(out), 32'h14);
    chk("t1_done", 32'(done), 32'h1);
    chk("t1_end_ready", 32'(cfg_ready), 32'h1);
    tick();
    chk("t1_done_pulse", 32'(done), 32'h0);

    // Target out3, hold 0: out3 overridden for one cycle only
    a = 8'h00;
    set_cfg(8'h0F, 8'h05, 8'h5A, 4'd0, 2'd2);
    tick();
    cfg_valid = 1'b0;
    a = 8'h25;
    tick();
    chk("t2_active", 32'(patch_active), 32'h1);
    chk("t2_out_untouched", 32'(out), 32'h24);
    chk("t2_out3_pre", 32'(out3), 32'h25);
    a = 8'h33;
    tick();
    chk("t2_out3_value", 32'(out3), 32'h5A);
    chk("t2_out", 32'(out), 32'h30);
    chk("t2_done", 32'(done), 32'h1);
    chk("t2_inactive", 32'(patch_active), 32'h0);
    tick();
    chk("t2_out3_track", 32'(out3), 32'h33);
    chk("t2_hit", 32'(hit_cnt), 32'h2);

    // Cfg offers while ARMED/ACTIVE are ignored; abort mid-ACTIVE
    a = 8'h00;
    set_cfg(8'hFF, 8'h77, 8'hC3, 4'd3, 2'd3);
    tick();
    set_cfg(8'h00, 8'h00, 8'h11, 4'd0, 2'd1);
    #1;
    chk("t3_armed_ready", 32'(cfg_ready), 32'h0);
    a = 8'h77;
    tick();
    chk("t3_c1_out", 32'(out), 32'hC3);
    chk("t3_c1_ready", 32'(cfg_ready), 32'h0);
    tick();
    chk("t3_c2_active", 32'(patch_active), 32'h1);
    chk("t3_c2_out", 32'(out), 32'hC3);
    abort = 1'b1; cfg_valid = 1'b0;
    tick();
    chk("t3_abort_active", 32'(patch_active), 32'h0);
    chk("t3_abort_done", 32'(done), 32'h0);
    chk("t3_abort_out", 32'(out), 32'h34);
    chk("t3_abort_ready", 32'(cfg_ready), 32'h1);
    abort = 1'b0;
    tick();
    chk("t3_abort_done2", 32'(done), 32'h0);
    chk("t3_hit", 32'(hit_cnt), 32'h3);

    // Mask 0 triggers on first ARMED cycle; reset during ACTIVE
    set_cfg(8'h00, 8'h00, 8'h99, 4'd5, 2'd3);
    tick();
    cfg_valid = 1'b0;
    tick();
    chk("t4_mask0_active", 32'(patch_active), 32'h1);
    chk("t4_out", 32'(out), 32'h99);
    chk("t4_out2", 32'(out2), 32'h7E);
    chk("t4_hit_sat", 32'(hit_cnt), 32'h3);
    tick();
    chk("t4_out3", 32'(out3), 32'h99);
    rst = 1'b1;
    tick();
    chk("t4_rst_active", 32'(patch_active), 32'h0);
    chk("t4_rst_out", 32'(out), 32'h34);
    chk("t4_rst_out2", 32'(out2), 32'hFF);
    chk("t4_rst_out3", 32'(out3), 32'h00);
    chk("t4_rst_hit", 32'(hit_cnt), 32'h0);
    chk("t4_rst_ready", 32'(cfg_ready), 32'h1);
    chk("t4_rst_done", 32'(done), 32'h0);
    rst = 1'b0;

    // Five triggers with a 2-bit hit counter
    for (int i = 0; i < 5; i++) begin
      set_cfg(8'h00, 8'h00, 8'h01, 4'd0, 2'd1);
      tick();
      cfg_valid = 1'b0;
      tick();
      chk("t5_active", 32'(patch_active), 32'h1);
      chk("t5_out", 32'(out), 32'h01);
      chk("t5_hit", 32'(hit_cnt), 32'(exp_hit[i]));
      tick();
      chk("t5_done", 32'(done), 32'h1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_patch_sample_node

// File: doc/patch_sample_node.md
# patch_sample_node

Parametrised successor to the single-bit sample node: a WIDTH-bit datapath with the same combinational/registered outputs, plus an integrated patch engine. The engine observes input `a` against a masked match pattern and, once triggered, overrides one selected output with a programmed value for a programmed number of cycles. It sits at a patchable leaf of the SoC and is configured over a valid/ready port by the patch controller.

## Interface
- `WIDTH`, 8: datapath width of `a`, `b`, `out`, `out2`, `out3`.
- `HOLD_W`, 4: width of the hold-length field; maximum override length is 2^HOLD_W cycles.
- `CNT_W`, 8: width of the saturating hit counter.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `a`  in  WIDTH  primary input; also the observe source.
- `b`  in  WIDTH  secondary input.
- `out`  out  WIDTH  a & b, or the override value.
- `out2`  out  WIDTH  ~out | b, always computed from the final `out`, patched or not.
- `out3`  out  WIDTH  registered a, or the override value.
- `cfg_valid`  in  1  configuration offer.
- `cfg_ready`  out  1  high only in IDLE.
- `cfg_mask`  in  WIDTH  bits participating in the match.
- `cfg_match`  in  WIDTH  match pattern.
- `cfg_value`  in  WIDTH  override value.
- `cfg_hold`  in  HOLD_W  override length minus one.
- `cfg_target`  in  2  0 = none, 1 = out, 2 = out3, 3 = both.
- `abort`  in  1  cancels any armed or active patch.
- `patch_active`  out  1  override currently applied.
- `done`  out  1  one-cycle pulse when an override completes normally.
- `hit_cnt`  out  CNT_W  count of triggers since reset; saturates at all-ones.

## Operation
- Configuration is accepted when `cfg_valid` and `cfg_ready` are both high; all cfg fields are latched on that edge.
- State machine:
  - IDLE: accepted cfg with target != 0 goes to ARMED. Accepted cfg with target 0 is latched and the FSM stays in IDLE.
  - ARMED: when (a & mask) == (match & mask), go to ACTIVE; the hold counter loads `cfg_hold` and `hit_cnt` increments.
  - ACTIVE: the override is applied. The counter decrements each cycle; when it reaches 0 in ACTIVE, go to IDLE and pulse `done`.
- `mask` = 0 matches on the first ARMED cycle.
- No match is evaluated in the cfg-acceptance cycle; matching starts the first cycle in ARMED.
- Override behaviour:
  - Target out: `out` = `cfg_value` combinationally while `patch_active`.
  - Target out3: the `out3` register captures `cfg_value` instead of `a` on each ACTIVE edge.
- `abort` is evaluated first in every state and moves the FSM to IDLE on the next edge, with no `done` pulse. `abort` together with a match in ARMED gives IDLE; the hit is not counted.
- `cfg_valid` outside IDLE is ignored; no latch occurs.

## Timing
- Reset values:
  - State IDLE, `cfg_ready` = 1, `patch_active` = 0, `done` = 0, `hit_cnt` = 0, `out3` = 0, all cfg registers 0.
  - During reset, `out` = a & b and `out2` follows it.
- `out` and `out2` have zero latency from `a`/`b`. `out3` has one-cycle latency.
- Trigger latency:
  - The match is sampled at edge T. `patch_active` and the `out` override are high from T through T + hold.
  - The override is applied for exactly `cfg_hold` + 1 cycles.
  - `done` is high for the one cycle after the last override cycle, and `cfg_ready` is high in the same cycle.
- Reset asserted mid-ACTIVE: the override drops after that edge, and `out3` is 0 on the following cycle.
- `hit_cnt` at all-ones does not wrap.

## Structure
- Shared package `patch_pkg`:
  - state enum (IDLE, ARMED, ACTIVE)
  - target enum (T_NONE, T_OUT, T_OUT3, T_BOTH)
  - hit-counter saturation helper function
- One sub-module, `patch_trigger_fsm`, holds the FSM, cfg registers, hold counter and hit counter. It exports `patch_active`, `tgt_out`, `tgt_out3` and `value`. The top-level datapath muxes on these signals.

## Test plan
- WIDTH=8. Reset, then a=0xF0, b=0x3C → out=0x30, out2=0xFF; one cycle later out3=0xF0; cfg_ready=1.
- Cfg mask=0x0F, match=0x05, value=0xAA, hold=2, target=1. Drive a=0x15 → out=0xAA and out2=0x55|b for exactly 3 cycles, done pulses once, hit_cnt=1.
- Target=2, hold=0, trigger → out3=value for exactly one cycle, then resumes tracking a; out is never overridden.
- Offer cfg_valid while ARMED and while ACTIVE → no latch, cfg_ready=0. Assert abort mid-ACTIVE → override ends next cycle, no done pulse.
- Assert rst during ACTIVE → all outputs at reset values next cycle; out3=0.
- CNT_W=2, trigger 5 times → hit_cnt sequence 1, 2, 3, 3, 3. Also apply mask=0 → trigger on the first ARMED cycle.
